// File: rtl/tt_pkg.sv
// Shared types and helpers for the truth-table evaluator.
package tt_pkg;

  typedef enum logic {TT_RUN, TT_LOAD} tt_state_e;

  localparam int unsigned TT_MAX_IN = 6;

  // Table width for an n-input function.
  function automatic int unsigned tt_width(input int unsigned n);
    return 32'd1 << n;
  endfunction

endpackage

// File: rtl/tt_cfg_shifter.sv
// Serial table loader: shadow register, beat counter and commit strobe.
module tt_cfg_shifter
  import tt_pkg::*;
#(
  parameter int unsigned TW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          restart,
  input  logic          load,
  input  logic          cfg_valid,
  input  logic          cfg_bit,
  output logic [TW-1:0] next_table_c,
  output logic          commit_c
);

  localparam int unsigned CW = $clog2(TW) + 1;

  logic [TW-1:0] shadow;
  logic [TW-1:0] shadow_base;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_base;
  logic          shift;

  // A restart clears the load first, so a bit in the same cycle counts as the first one.
  always_comb begin
    shadow_base  = restart ? '0 : shadow;
    cnt_base     = restart ? '0 : cnt;
    shift        = load && cfg_valid;
    next_table_c = {shadow_base[TW-2:0], cfg_bit};
    commit_c     = shift && (cnt_base == CW'(TW - 1));
  end

  // Shadow and counter update.
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow <= '0;
      cnt    <= '0;
    end else if (shift) begin
      shadow <= next_table_c;
      cnt    <= commit_c ? '0 : cnt_base + CW'(1);
    end else if (restart) begin
      shadow <= '0;
      cnt    <= '0;
    end
  end

endmodule

// File: rtl/truth_table_eval.sv
// Runtime-reprogrammable N-input truth-table evaluator with valid/ready output.
// Optional feature: define TT_READBACK_EN to expose the active table on table_q.
module truth_table_eval
  import tt_pkg::*;
#(
  parameter  int unsigned N_IN = 3,
  localparam int unsigned TW   = tt_width(N_IN),
  parameter  logic [TW-1:0] DEFAULT_TABLE = 8'hD3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            cfg_start,
  input  logic            cfg_valid,
  input  logic            cfg_bit,
  output logic            cfg_busy,
  output logic            cfg_done,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [N_IN-1:0] in_vec,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            out
`ifdef TT_READBACK_EN
  ,
  output logic [TW-1:0]   table_q
`endif
);

  tt_state_e       state;
  tt_state_e       state_next;
  logic [TW-1:0]   active_table;
  logic [TW-1:0]   next_table_c;
  logic            commit_c;
  logic            accept_c;
  logic [N_IN-1:0] row_c;

  tt_cfg_shifter #(.TW(TW)) u_shifter (
    .clk          (clk),
    .rst          (rst),
    .restart      (cfg_start),
    .load         (state == TT_LOAD),
    .cfg_valid    (cfg_valid),
    .cfg_bit      (cfg_bit),
    .next_table_c (next_table_c),
    .commit_c     (commit_c)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state <= TT_RUN;
    else     state <= state_next;
  end

  // FSM next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      TT_RUN:  if (cfg_start) state_next = TT_LOAD;
      TT_LOAD: if (commit_c)  state_next = TT_RUN;
    endcase
  end

  assign cfg_busy = (state == TT_LOAD);

  // Active table swaps in on commit; done pulses the following cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      active_table <= DEFAULT_TABLE;
      cfg_done     <= 1'b0;
    end else begin
      if (commit_c) active_table <= next_table_c;
      cfg_done <= commit_c;
    end
  end

  // Row 0 lives at the table MSB, so the bit index is the inverted input.
  assign row_c    = ~in_vec;
  assign in_ready = !out_valid || out_ready;
  assign accept_c = in_valid && in_ready;

  // One-entry output register.
  always_ff @(posedge clk) begin
    if (rst) begin
      out       <= 1'b0;
      out_valid <= 1'b0;
    end else if (accept_c) begin
      out       <= active_table[row_c];
      out_valid <= 1'b1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef TT_READBACK_EN
  assign table_q = active_table;
`endif

endmodule

// File: tb/tb_truth_table_eval.sv
// Scoreboard bench: a 3-input and a 2-input evaluator share one stimulus stream.
module tb_truth_table_eval;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cfg_start = 1'b0, cfg_valid = 1'b0, cfg_bit = 1'b0;
  logic       in_valid = 1'b0, out_ready = 1'b1;
  logic [2:0] in_vec = '0;

  logic a_busy, a_done, a_in_ready, a_out_valid, a_out;
  logic b_busy, b_done, b_in_ready, b_out_valid, b_out;
`ifdef TT_READBACK_EN
  logic [7:0] a_tq;
  logic [3:0] b_tq;
`endif

  always #5 clk = ~clk;

  truth_table_eval #(.N_IN(3), .DEFAULT_TABLE(8'hD3)) u_a (
    .clk(clk), .rst(rst), .cfg_start(cfg_start), .cfg_valid(cfg_valid), .cfg_bit(cfg_bit),
    .cfg_busy(a_busy), .cfg_done(a_done), .in_valid(in_valid), .in_ready(a_in_ready),
    .in_vec(in_vec), .out_valid(a_out_valid), .out_ready(out_ready), .out(a_out)
`ifdef TT_READBACK_EN
    , .table_q(a_tq)
`endif
  );

  truth_table_eval #(.N_IN(2), .DEFAULT_TABLE(4'b0110)) u_b (
    .clk(clk), .rst(rst), .cfg_start(cfg_start), .cfg_valid(cfg_valid), .cfg_bit(cfg_bit),
    .cfg_busy(b_busy), .cfg_done(b_done), .in_valid(in_valid), .in_ready(b_in_ready),
    .in_vec(in_vec[1:0]), .out_valid(b_out_valid), .out_ready(out_ready), .out(b_out)
`ifdef TT_READBACK_EN
    , .table_q(b_tq)
`endif
  );

  int errors = 0;
  int checks = 0;

  // Reference model, one slot per DUT (0: 3-input, 1: 2-input).
  int unsigned tw[2]     = '{8, 4};
  int unsigned dflt[2]   = '{32'hD3, 32'h6};
  int unsigned m_tbl[2];
  int unsigned m_sh[2];
  int unsigned m_cnt[2];
  bit          m_load[2];
  bit          done_pend[2];
  bit          q0[$];
  bit          q1[$];
  bit          prev_acc_a, prev_acc_b, prev_hold, prev_out_a, prev_out_b;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  function automatic bit expv(input int k, input int unsigned vec);
    int unsigned idx;
    idx = vec % tw[k];
    return bit'((m_tbl[k] >> (tw[k] - 1 - idx)) & 1);
  endfunction

  // Table load rules applied to one cycle of cfg inputs.
  task automatic model_cfg(input int k, input bit cs, input bit cv, input bit cb);
    if (cs) begin
      m_cnt[k] = 0;
      m_sh[k]  = 0;
      if (!m_load[k]) begin
        m_load[k] = 1'b1;
        return;
      end
    end
    if (m_load[k] && cv) begin
      m_sh[k] = ((m_sh[k] << 1) | int'(cb)) % (32'd1 << tw[k]);
      m_cnt[k]++;
      if (m_cnt[k] == tw[k]) begin
        m_tbl[k]     = m_sh[k];
        m_load[k]    = 1'b0;
        done_pend[k] = 1'b1;
      end
    end
  endtask

  task automatic reset_dut();
    @(posedge clk); #1;
    rst = 1'b1; in_valid = 0; cfg_start = 0; cfg_valid = 0; out_ready = 1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    for (int k = 0; k < 2; k++) begin
      m_tbl[k] = dflt[k]; m_sh[k] = 0; m_cnt[k] = 0; m_load[k] = 0; done_pend[k] = 0;
    end
    q0.delete(); q1.delete();
    prev_acc_a = 0; prev_acc_b = 0; prev_hold = 0;
    @(negedge clk);
    chk("rst_out_valid", a_out_valid, 0);
    chk("rst_out", a_out, 0);
    chk("rst_in_ready", a_in_ready, 1);
    chk("rst_busy", a_busy, 0);
    chk("rst_done", a_done, 0);
    chk("rst_b_out_valid", b_out_valid, 0);
    chk("rst_b_in_ready", b_in_ready, 1);
    prev_out_a = a_out; prev_out_b = b_out;
  endtask

  // One clock of stimulus; expectations are queued for the monitor.
  task automatic cycle(input bit iv, input int unsigned vec, input bit ordy,
                       input bit cs, input bit cv, input bit cb);
    bit acc_a, acc_b;
    @(posedge clk); #1;
    in_valid = iv; in_vec = 3'(vec); out_ready = ordy;
    cfg_start = cs; cfg_valid = cv; cfg_bit = cb;
    @(negedge clk);
    chk("busy_a", a_busy, 32'(m_load[0]));
    chk("busy_b", b_busy, 32'(m_load[1]));
    chk("done_a", a_done, 32'(done_pend[0]));
    chk("done_b", b_done, 32'(done_pend[1]));
`ifdef TT_READBACK_EN
    chk("table_q_a", 32'(a_tq), m_tbl[0]);
    chk("table_q_b", 32'(b_tq), m_tbl[1]);
`endif
    if (prev_acc_a) chk("latency_a", a_out_valid, 1);
    if (prev_acc_b) chk("latency_b", b_out_valid, 1);
    if (prev_hold) begin
      chk("hold_a", a_out, 32'(prev_out_a));
      chk("hold_b", b_out, 32'(prev_out_b));
    end
    done_pend[0] = 0; done_pend[1] = 0;
    acc_a = in_valid && a_in_ready;
    acc_b = in_valid && b_in_ready;
    if (acc_a) q0.push_back(expv(0, vec));
    if (acc_b) q1.push_back(expv(1, vec));
    prev_acc_a = acc_a; prev_acc_b = acc_b;
    prev_hold  = a_out_valid && !out_ready;
    prev_out_a = a_out; prev_out_b = b_out;
    model_cfg(0, cs, cv, cb);
    model_cfg(1, cs, cv, cb);
  endtask

  task automatic load_word(input int unsigned word, input int unsigned nbits);
    int unsigned i;
    cycle(0, 0, 1, 1, 0, 0);
    i = 0;
    while (i < nbits) begin
      if ($urandom_range(0, 2) == 0) cycle(0, 0, 1, 0, 0, 1);
      else begin
        cycle(0, 0, 1, 0, 1, bit'((word >> (nbits - 1 - i)) & 1));
        i++;
      end
    end
  endtask

  task automatic sweep();
    for (int v = 0; v < 8; v++) cycle(1, v, 1, 0, 0, 0);
    cycle(0, 0, 1, 0, 0, 0);
  endtask

  // Monitor: compare each result as it is handed downstream.
  always @(negedge clk) begin
    if (!rst) begin
      if (a_out_valid && out_ready) begin
        if (q0.size() == 0) chk("a_unexpected_out", 1, 0);
        else chk("a_out", a_out, 32'(q0.pop_front()));
      end
      if (b_out_valid && out_ready) begin
        if (q1.size() == 0) chk("b_unexpected_out", 1, 0);
        else chk("b_out", b_out, 32'(q1.pop_front()));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_dut();
    sweep();                               // D3 -> 1,1,0,1,0,0,1,1
    load_word(32'h96, 8);                  // gaps in cfg_valid
    sweep();
    // Final bit of 8'h00 together with an accept of 3'b011: old table applies.
    cycle(0, 0, 1, 1, 0, 0);
    for (int i = 0; i < 7; i++) cycle(0, 0, 1, 0, 1, 0);
    cycle(1, 3, 1, 0, 1, 0);
    cycle(1, 3, 1, 0, 0, 0);
    cycle(0, 0, 1, 0, 0, 0);
    // Backpressure.
    cycle(1, 5, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      cycle(1, 6, 0, 0, 0, 0);
      chk("bp_in_ready", a_in_ready, 0);
    end
    cycle(1, 6, 1, 0, 0, 0);
    chk("release_in_ready", a_in_ready, 1);
    cycle(0, 0, 1, 0, 0, 0);
    // Reset in the middle of a load.
    cycle(0, 0, 1, 1, 0, 0);
    for (int i = 0; i < 4; i++) cycle(0, 0, 1, 0, 1, 1);
    reset_dut();
    cycle(0, 0, 1, 0, 0, 0);
    cycle(1, 2, 1, 0, 0, 0);
    cycle(0, 0, 1, 0, 0, 0);
    // 8'h80 stream: the 2-input table commits 4'b1000 after four bits.
    load_word(32'h80, 8);
    sweep();
    // Randomized traffic.
    for (int i = 0; i < 400; i++)
      cycle(bit'($urandom_range(0, 1)), $urandom_range(0, 7), bit'($urandom_range(0, 3) != 0),
            $urandom_range(0, 24) == 0, bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)));
    for (int i = 0; i < 3; i++) cycle(0, 0, 1, 0, 0, 0);
    chk("drain_a", q0.size(), 0);
    chk("drain_b", q1.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
